// File: rtl/global_types.sv
// Shared Avalon-ST beat type, arbiter state encoding and sizing constant for the TX path.
package global_types;

  // 1536-byte frame at 32 bits per beat
  localparam int MAX_WORDS_DEF = 384;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic        valid;
  } avln_st;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FWD   = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the side not granted last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is taken.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/tx_pkt_arbiter.sv
// Packet-atomic 2:1 Avalon-ST arbiter for the TSE transmit port; ARB_STATS_EN adds per-source counters.
// Latency: one idle bubble to register the grant, then zero-latency pass-through of the owner.
// Backpressure: owner's ready follows out_ready; loser held off; orphans and over-length tails discarded.
module tx_pkt_arbiter
  import global_types::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic        sys_clk,
  input  logic        core_reset_n,
  input  avln_st      in0,
  output logic        in0_ready,
  input  avln_st      in1,
  output logic        in1_ready,
  output avln_st      out,
  input  logic        out_ready,
  output logic [1:0]  grant,
  output logic        trunc_flag,
  output logic        orphan_flag,
  output logic [15:0] pkt_cnt0,
  output logic [15:0] pkt_cnt1,
  output logic [7:0]  trunc_cnt
);

  localparam int CW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_WORDS - 1);

  arb_state_t    state, state_nxt;
  logic [1:0]    grant_nxt, req, pick;
  logic          last, last_nxt;
  logic [CW-1:0] beat_cnt, beat_nxt;
  avln_st        sel;
  logic          rdy0, rdy1, accept, at_limit, orphan_set, trunc_set;

  assign sel      = grant[1] ? in1 : in0;
  assign req      = {in1.valid & in1.sop, in0.valid & in0.sop};
  assign at_limit = (beat_cnt == LAST_IDX) && !sel.eop;

  rr_pick2 u_pick (
    .req  (req),
    .last (last),
    .pick (pick)
  );

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    last_nxt   = last;
    beat_nxt   = beat_cnt;
    out        = '0;
    rdy0       = 1'b0;
    rdy1       = 1'b0;
    accept     = 1'b0;
    orphan_set = 1'b0;
    trunc_set  = 1'b0;
    case (state)
      ARB_IDLE: begin
        // sop beats stay on the input; only mid-packet strays are swallowed here
        rdy0       = in0.valid & ~in0.sop;
        rdy1       = in1.valid & ~in1.sop;
        orphan_set = rdy0 | rdy1;
        if (pick != 2'b00) begin
          state_nxt = ARB_FWD;
          grant_nxt = pick;
          beat_nxt  = '0;
        end
      end
      ARB_FWD: begin
        out = sel;
        if (at_limit) begin
          out.eop   = 1'b1;
          out.empty = 2'b00;
        end
        rdy0   = grant[0] & out_ready;
        rdy1   = grant[1] & out_ready;
        accept = sel.valid & out_ready;
        if (accept) begin
          if (sel.eop) begin
            state_nxt = ARB_IDLE;
            grant_nxt = 2'b00;
            last_nxt  = grant[1];
          end else if (at_limit) begin
            state_nxt = ARB_DRAIN;
            last_nxt  = grant[1];
            trunc_set = 1'b1;
          end else begin
            beat_nxt = beat_cnt + 1'b1;
          end
        end
      end
      ARB_DRAIN: begin
        rdy0 = grant[0];
        rdy1 = grant[1];
        if (sel.valid & sel.eop) begin
          state_nxt = ARB_IDLE;
          grant_nxt = 2'b00;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  assign in0_ready = rdy0 & core_reset_n;
  assign in1_ready = rdy1 & core_reset_n;

  always_ff @(posedge sys_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      state       <= ARB_IDLE;
      grant       <= 2'b00;
      last        <= 1'b1;
      beat_cnt    <= '0;
      trunc_flag  <= 1'b0;
      orphan_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      last     <= last_nxt;
      beat_cnt <= beat_nxt;
      if (trunc_set)  trunc_flag  <= 1'b1;
      if (orphan_set) orphan_flag <= 1'b1;
    end
  end

`ifdef ARB_STATS_EN
  // a forced eop closes a packet just like a real one
  always_ff @(posedge sys_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      pkt_cnt0  <= '0;
      pkt_cnt1  <= '0;
      trunc_cnt <= '0;
    end else begin
      if (accept && out.eop && grant[0]) pkt_cnt0 <= pkt_cnt0 + 16'd1;
      if (accept && out.eop && grant[1]) pkt_cnt1 <= pkt_cnt1 + 16'd1;
      if (trunc_set && (trunc_cnt != 8'hFF)) trunc_cnt <= trunc_cnt + 8'd1;
    end
  end
`else
  assign pkt_cnt0  = '0;
  assign pkt_cnt1  = '0;
  assign trunc_cnt = '0;
`endif

endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// Randomized bench for tx_pkt_arbiter: per-source packet queues drive the inputs and a
// packet-level model predicts each source's output stream, grant order, flags and counters.
module tb_tx_pkt_arbiter;
  import global_types::*;

  localparam int MW = 8;

  logic        sys_clk = 1'b0;
  logic        core_reset_n;
  avln_st      in0, in1, out;
  logic        in0_ready, in1_ready, out_ready;
  logic [1:0]  grant;
  logic        trunc_flag, orphan_flag;
  logic [15:0] pkt_cnt0, pkt_cnt1;
  logic [7:0]  trunc_cnt;

  always #5 sys_clk = ~sys_clk;

  tx_pkt_arbiter #(.MAX_WORDS(MW)) dut (
    .sys_clk      (sys_clk),
    .core_reset_n (core_reset_n),
    .in0          (in0),
    .in0_ready    (in0_ready),
    .in1          (in1),
    .in1_ready    (in1_ready),
    .out          (out),
    .out_ready    (out_ready),
    .grant        (grant),
    .trunc_flag   (trunc_flag),
    .orphan_flag  (orphan_flag),
    .pkt_cnt0     (pkt_cnt0),
    .pkt_cnt1     (pkt_cnt1),
    .trunc_cnt    (trunc_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  avln_st     src_q[2][$];
  avln_st     exp_q[2][$];
  avln_st     cur[2];
  bit         xfer[2];
  logic [1:0] order_q[$];
  logic [1:0] prev_grant;
  int         gap_pct, ordy_pct, acc_cnt;
  bit         ordy_toggle;
  int         exp_pkts[2];
  int         exp_trunc;
  bit         exp_trunc_flag, exp_orphan;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Queue one packet; the expected output is its first MW beats, with the last one
  // turned into an eop/empty=0 when the packet is longer than MW.
  task automatic add_pkt(input int s, input int len, input bit orphan_first);
    avln_st b, e;
    if (orphan_first) begin
      b = '0;
      b.valid = 1'b1;
      b.data = $urandom;
      src_q[s].push_back(b);
      exp_orphan = 1'b1;
    end
    for (int i = 0; i < len; i++) begin
      b = '0;
      b.valid = 1'b1;
      b.data  = $urandom;
      b.sop   = (i == 0) || ($urandom_range(0, 9) == 0);
      b.eop   = (i == len - 1);
      b.empty = 2'($urandom_range(0, 3));
      src_q[s].push_back(b);
      if (i < MW) begin
        e = b;
        if (i == MW - 1 && len > MW) begin
          e.eop   = 1'b1;
          e.empty = 2'b00;
        end
        exp_q[s].push_back(e);
      end
    end
    exp_pkts[s]++;
    if (len > MW) begin
      exp_trunc++;
      exp_trunc_flag = 1'b1;
    end
  endtask

  task automatic sample();
    avln_st e;
    int s;
    @(negedge sys_clk);
    xfer[0] = cur[0].valid && in0_ready;
    xfer[1] = cur[1].valid && in1_ready;
    if (prev_grant == 2'b00 && grant != 2'b00) order_q.push_back(grant);
    prev_grant = grant;
    if (grant == 2'b00) begin
      check_val("idle_out_valid", out.valid, 0);
    end else begin
      check_val("grant_onehot", $onehot(grant), 1);
      check_val("nongrant_ready", grant[0] ? in1_ready : in0_ready, 0);
      if (out.valid && out_ready) begin
        acc_cnt++;
        s = grant[1] ? 1 : 0;
        check_val("beat_expected", exp_q[s].size() > 0, 1);
        if (exp_q[s].size() > 0) begin
          e = exp_q[s].pop_front();
          check_val("beat", {out.data, out.sop, out.eop, out.empty},
                    {e.data, e.sop, e.eop, e.empty});
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      if (xfer[s]) cur[s].valid = 1'b0;
      xfer[s] = 1'b0;
      if (!cur[s].valid && src_q[s].size() > 0 && $urandom_range(0, 99) < gap_pct)
        cur[s] = src_q[s].pop_front();
    end
    in0 = cur[0];
    in1 = cur[1];
    if (ordy_toggle) out_ready = ~out_ready;
    else out_ready = ($urandom_range(0, 99) < ordy_pct);
  endtask

  task automatic cycle();
    sample();
    tick();
  endtask

  function automatic bit quiet();
    return src_q[0].size() == 0 && src_q[1].size() == 0 && !cur[0].valid && !cur[1].valid &&
           exp_q[0].size() == 0 && exp_q[1].size() == 0;
  endfunction

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    while (!quiet() && n < budget) begin
      cycle();
      n++;
    end
    check_val({tag, "_completed"}, quiet(), 1);
    repeat (3) cycle();
  endtask

  task automatic check_status(input string tag);
    check_val({tag, "_grant"}, grant, 0);
    check_val({tag, "_trunc_flag"}, trunc_flag, exp_trunc_flag);
    check_val({tag, "_orphan_flag"}, orphan_flag, exp_orphan);
`ifdef ARB_STATS_EN
    check_val({tag, "_pkt_cnt0"}, pkt_cnt0, exp_pkts[0] % 65536);
    check_val({tag, "_pkt_cnt1"}, pkt_cnt1, exp_pkts[1] % 65536);
    check_val({tag, "_trunc_cnt"}, trunc_cnt, (exp_trunc > 255) ? 255 : exp_trunc);
`else
    check_val({tag, "_pkt_cnt0"}, pkt_cnt0, 0);
    check_val({tag, "_pkt_cnt1"}, pkt_cnt1, 0);
    check_val({tag, "_trunc_cnt"}, trunc_cnt, 0);
`endif
  endtask

  task automatic do_reset();
    core_reset_n = 1'b0;
    cur[0] = '0;
    cur[1] = '0;
    in0 = '0;
    in1 = '0;
    for (int s = 0; s < 2; s++) begin
      src_q[s].delete();
      exp_q[s].delete();
      exp_pkts[s] = 0;
      xfer[s] = 1'b0;
    end
    exp_trunc = 0;
    exp_trunc_flag = 1'b0;
    exp_orphan = 1'b0;
    prev_grant = 2'b00;
    order_q.delete();
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    core_reset_n = 1'b1;
  endtask

  task automatic check_order(input string tag, input int n);
    check_val({tag, "_grants"}, order_q.size(), n);
    for (int i = 0; i < n && i < order_q.size(); i++)
      check_val({tag, "_order"}, order_q[i], (i % 2 == 0) ? 2'b01 : 2'b10);
  endtask

  initial begin
    int a0, n;
    out_ready = 1'b0;
    gap_pct = 100;
    ordy_pct = 100;
    ordy_toggle = 1'b0;
    acc_cnt = 0;
    do_reset();

    // reset state
    check_val("rst_out_valid", out.valid, 0);
    check_val("rst_in0_ready", in0_ready, 0);
    check_val("rst_in1_ready", in1_ready, 0);
    check_status("rst");

    // full-length packet from source 0: grant appears one cycle after sop
    add_pkt(0, MW, 0);
    a0 = acc_cnt;
    cycle();
    sample();
    check_val("t1_grant_sop_cycle", grant, 2'b00);
    check_val("t1_sop_not_taken", in0_ready, 0);
    tick();
    sample();
    check_val("t1_grant", grant, 2'b01);
    check_val("t1_out_valid", out.valid, 1);
    tick();
    run_until_idle("t1", 200);
    check_val("t1_beats", acc_cnt - a0, MW);
    check_status("t1");

    // simultaneous sops after reset alternate starting with source 0
    do_reset();
    add_pkt(0, 3, 0);
    add_pkt(1, 3, 0);
    add_pkt(0, 2, 0);
    add_pkt(1, 2, 0);
    run_until_idle("tie", 300);
    check_order("tie", 4);
    check_status("tie");

    // out_ready toggling every cycle while source 1 waits
    ordy_toggle = 1'b1;
    add_pkt(0, 6, 0);
    add_pkt(1, 4, 0);
    run_until_idle("toggle", 300);
    ordy_toggle = 1'b0;
    check_status("toggle");

    // over-length packet is cut at MW beats and the tail drained
    a0 = acc_cnt;
    add_pkt(1, 12, 0);
    run_until_idle("trunc", 300);
    check_val("trunc_beats", acc_cnt - a0, MW);
    check_status("trunc");

    // stray beat in idle is dropped, following packet unaffected
    add_pkt(0, 4, 1);
    run_until_idle("orphan", 300);
    check_status("orphan");

    // reset in the middle of a packet
    add_pkt(0, 20, 0);
    a0 = acc_cnt;
    n = 0;
    while (acc_cnt - a0 < 5 && n < 100) begin
      cycle();
      n++;
    end
    check_val("mid_rst_reached", acc_cnt - a0 >= 5, 1);
    core_reset_n = 1'b0;
    #1;
    check_val("mid_rst_out_valid", out.valid, 0);
    check_val("mid_rst_grant", grant, 0);
    check_val("mid_rst_in0_ready", in0_ready, 0);
    do_reset();
    check_status("mid_rst");
    add_pkt(1, 2, 0);
    add_pkt(0, 2, 0);
    run_until_idle("post_rst", 200);
    check_order("post_rst", 2);
    check_status("post_rst");

    // randomized traffic with gaps, backpressure, orphans and truncations
    gap_pct = 70;
    ordy_pct = 75;
    for (int i = 0; i < 30; i++) begin
      add_pkt(0, $urandom_range(1, 14), $urandom_range(0, 4) == 0);
      add_pkt(1, $urandom_range(1, 14), $urandom_range(0, 4) == 0);
    end
    run_until_idle("rand", 20000);
    check_status("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
